bcd_serial_add_ctrl: RTL and testbench

//   Digit-serial 8421-BCD add/subtract engine: one shared 4-bit BCD digit adder,

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_digit_add.sv | 33 +++
 rtl/bcd_serial_add_ctrl.sv | 171 +++++++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : bcd_pkg                                                         |
// | Brief  : Shared constants for the digit-serial BCD add/subtract engine.  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
package bcd_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [3:0] BCD_NINE      = 4'd9;
  localparam logic [3:0] BCD_SIX       = 4'd6;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return BCD_NINE - d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : bcd_digit_add                                                   |
// | Brief  : Combinational single-digit 8421-BCD adder with invalid flag.    |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       invalid
);

  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (raw > {1'b0, BCD_MAX_DIGIT}) begin
      sum  = raw[3:0] + BCD_SIX;
      cout = 1'b1;
    end else begin
      sum  = raw[3:0];
      cout = 1'b0;
    end
    invalid = (a > BCD_MAX_DIGIT) || (b > BCD_MAX_DIGIT);
  end

endmodule
`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : bcd_serial_add_ctrl                                             |
// | Brief  : Digit-serial BCD add/subtract controller, LSB digit first.      |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  Cin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   Y,
  output logic                  Cout,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [1:0]       state_q,   state_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [W-1:0]     a_q,       a_d;
  logic [W-1:0]     b_q,       b_d;
  logic             op_q,      op_d;
  logic             carry_q,   carry_d;
  logic             err_acc_q, err_acc_d;
  logic [W-1:0]     shadow_q,  shadow_d;
  logic [W-1:0]     y_q,       y_d;
  logic             cout_q,    cout_d;
  logic             err_q,     err_d;

  logic [3:0]   a_dig;
  logic [3:0]   b_dig;
  logic [3:0]   b_eff;
  logic [3:0]   sum_dig;
  logic         dig_cout;
  logic         dig_invalid;
  logic [W-1:0] shadow_next;
  logic         accept;

  always_comb begin
    a_dig = a_q[4*int'(idx_q) +: 4];
    b_dig = b_q[4*int'(idx_q) +: 4];
    // An invalid B digit bypasses the complement so the adder still flags it.
    if ((op_q == OP_SUB) && (b_dig <= BCD_MAX_DIGIT)) begin
      b_eff = nines_comp(b_dig);
    end else begin
      b_eff = b_dig;
    end
  end

  bcd_digit_add u_digit_add (
    .a       (a_dig),
    .b       (b_eff),
    .cin     (carry_q),
    .sum     (sum_dig),
    .cout    (dig_cout),
    .invalid (dig_invalid)
  );

  always_comb begin
    shadow_next = shadow_q;
    shadow_next[4*int'(idx_q) +: 4] = sum_dig;
  end

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign done   = (state_q == ST_DONE);
  assign accept = start && ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    carry_d   = carry_q;
    err_acc_d = err_acc_q;
    shadow_d  = shadow_q;
    y_d       = y_q;
    cout_d    = cout_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        idx_d     = idx_q + IDX_W'(1);
        carry_d   = dig_cout;
        err_acc_d = err_acc_q | dig_invalid;
        shadow_d  = shadow_next;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          idx_d   = '0;
          if (err_acc_q || dig_invalid) begin
            y_d    = '0;
            cout_d = 1'b0;
            err_d  = 1'b1;
          end else begin
            y_d    = shadow_next;
            cout_d = dig_cout;
            err_d  = 1'b0;
          end
        end
      end
      ST_DONE: begin
        state_d = start ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Published Y/Cout/err stay untouched here; only the working set reloads.
    if (accept) begin
      a_d       = A;
      b_d       = B;
      op_d      = op;
      carry_d   = (op == OP_SUB) ? 1'b1 : Cin;
      err_acc_d = 1'b0;
      idx_d     = '0;
      shadow_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      carry_q   <= 1'b0;
      err_acc_q <= 1'b0;
      shadow_q  <= '0;
      y_q       <= '0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      carry_q   <= carry_d;
      err_acc_q <= err_acc_d;
      shadow_q  <= shadow_d;
      y_q       <= y_d;
      cout_q    <= cout_d;
      err_q     <= err_d;
    end
  end

  assign Y    = y_q;
  assign Cout = cout_q;
  assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_bcd_serial_add_ctrl                                          |
// | Brief  : Randomized + directed bench with a decimal-arithmetic model.    |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_bcd_serial_add_ctrl;

  localparam int D   = 4;
  localparam int P10 = 10000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic [4*D-1:0] a = '0;
  logic [4*D-1:0] b = '0;
  logic          cin = 1'b0;
  logic          ready;
  logic          done;
  logic [4*D-1:0] y;
  logic          cout;
  logic          err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: a countdown of remaining RUN cycles plus decimal results.
  int             m_busy = 0;
  bit             m_done = 1'b0;
  logic [4*D-1:0] m_y = '0;
  bit             m_cout = 1'b0;
  bit             m_err = 1'b0;
  logic [4*D-1:0] p_y = '0;
  bit             p_cout = 1'b0;
  bit             p_err = 1'b0;

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (a),
    .B     (b),
    .Cin   (cin),
    .ready (ready),
    .done  (done),
    .Y     (y),
    .Cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic bit bcd_ok(input logic [4*D-1:0] v);
    for (int i = 0; i < D; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [4*D-1:0] v);
    int r;
    r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [4*D-1:0] int2bcd(input int n);
    logic [4*D-1:0] r;
    int t;
    t = n;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    bit acc;
    int s;
    if (!rst_n) begin
      m_busy = 0;
      m_done = 1'b0;
      m_y    = '0;
      m_cout = 1'b0;
      m_err  = 1'b0;
    end else begin
      acc = start && (m_busy == 0);
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_done = 1'b1;
          m_y    = p_y;
          m_cout = p_cout;
          m_err  = p_err;
        end
      end else begin
        m_done = 1'b0;
      end
      if (acc) begin
        if (!(bcd_ok(a) && bcd_ok(b))) begin
          p_y = '0; p_cout = 1'b0; p_err = 1'b1;
        end else if (op == 1'b0) begin
          s = bcd2int(a) + bcd2int(b) + int'(cin);
          p_y = int2bcd(s % P10); p_cout = (s >= P10); p_err = 1'b0;
        end else begin
          s = bcd2int(a) - bcd2int(b);
          p_cout = (s >= 0); p_err = 1'b0;
          p_y = int2bcd((s < 0) ? s + P10 : s);
        end
        m_busy = D;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", 32'(ready), 32'(m_busy == 0));
      chk("done",  32'(done),  32'(m_done));
      chk("Y",     32'(y),     32'(m_y));
      chk("Cout",  32'(cout),  32'(m_cout));
      chk("err",   32'(err),   32'(m_err));
    end
  end

  // Caller sits just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic o, input logic [4*D-1:0] av, input logic [4*D-1:0] bv,
                       input logic c);
    int k;
    k = 0;
    while (!ready && k < 20) begin
      @(posedge clk); #2;
      k++;
    end
    chk("issue_ready", 32'(ready), 32'd1);
    start = 1'b1; op = o; a = av; b = bv; cin = c;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lat, input logic [4*D-1:0] ey,
                           input logic ec, input logic ee);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    while (k < 20 && !seen) begin
      @(negedge clk);
      k++;
      if (done) seen = 1'b1;
    end
    chk({nm, "_latency"}, 32'(k), 32'(lat));
    chk({nm, "_Y"}, 32'(y), 32'(ey));
    chk({nm, "_Cout"}, 32'(cout), 32'(ec));
    chk({nm, "_err"}, 32'(err), 32'(ee));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_Y", 32'(y), 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    issue(1'b0, 16'h1234, 16'h5678, 1'b0);
    wait_done("add_basic", 5, 16'h6912, 1'b0, 1'b0);
    @(posedge clk); #2;
    issue(1'b0, 16'h9999, 16'h0001, 1'b0);
    wait_done("add_ovf", 5, 16'h0000, 1'b1, 1'b0);
    @(posedge clk); #2;
    issue(1'b0, 16'h0000, 16'h0000, 1'b1);
    wait_done("add_cin", 5, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #2;
    issue(1'b1, 16'h5000, 16'h1234, 1'b0);
    wait_done("sub_basic", 5, 16'h3766, 1'b1, 1'b0);
    @(posedge clk); #2;
    issue(1'b1, 16'h0001, 16'h0002, 1'b1);
    wait_done("sub_borrow", 5, 16'h9999, 1'b0, 1'b0);
    @(posedge clk); #2;
    issue(1'b0, 16'h00A0, 16'h0001, 1'b0);
    wait_done("add_invalid", 5, 16'h0000, 1'b0, 1'b1);
    @(posedge clk); #2;
    issue(1'b0, 16'h0001, 16'h0001, 1'b0);
    wait_done("err_clear", 5, 16'h0002, 1'b0, 1'b0);
    @(posedge clk); #2;

    // A start pulse mid-run with other operands must leave the result alone.
    issue(1'b0, 16'h1111, 16'h2222, 1'b0);
    start = 1'b1; op = 1'b1; a = 16'h9999; b = 16'h8888; cin = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done("run_ignore", 4, 16'h3333, 1'b0, 1'b0);
    @(posedge clk); #2;

    issue(1'b0, 16'h1234, 16'h1111, 1'b0);
    wait_done("b2b_first", 5, 16'h2345, 1'b0, 1'b0);
    start = 1'b1; op = 1'b1; a = 16'h0500; b = 16'h0250; cin = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done("b2b_second", 5, 16'h0250, 1'b1, 1'b0);
    @(posedge clk); #2;

    issue(1'b0, 16'h4321, 16'h1234, 1'b0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_Y", 32'(y), 32'h0);
    chk("midrst_Cout", 32'(cout), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    @(posedge clk); #2;

    for (int n = 0; n < 1500; n++) begin
      start = ($urandom_range(0, 2) == 0);
      op    = 1'($urandom_range(0, 1));
      cin   = 1'($urandom_range(0, 1));
      for (int i = 0; i < D; i++) begin
        a[4*i +: 4] = 4'($urandom_range(0, 9));
        b[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 19) == 0) a[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 19) == 0) b[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      rst_n = ($urandom_range(0, 299) != 0);
      @(posedge clk); #2;
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
